// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: register address split, immediate
// generation, control decode, writeback bypass and the ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN           = 32,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            ValidD,
  input  logic            StallE,
  input  logic            FlushE,
  output logic [4:0]      A1,
  output logic [4:0]      A2,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ValidE,
  output logic            IllegalE
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            valid;
    logic            illegal;
  } idex_t;

  idex_t idex_q, idex_d, dec;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     imm32;
  logic            illegal;
  logic [XLEN-1:0] rd1_byp;
  logic [XLEN-1:0] rd2_byp;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];
  assign A1     = InstrD[19:15];
  assign A2     = InstrD[24:20];

  // x0 is hard-wired; a same-cycle writeback wins over the stale file read.
  always_comb begin
    rd1_byp = RD1;
    if (A1 == 5'd0) begin
      rd1_byp = '0;
    end else if (RegWriteW && (RdW == A1)) begin
      rd1_byp = ResultW;
    end
  end

  always_comb begin
    rd2_byp = RD2;
    if (A2 == 5'd0) begin
      rd2_byp = '0;
    end else if (RegWriteW && (RdW == A2)) begin
      rd2_byp = ResultW;
    end
  end

  always_comb begin
    dec     = '0;
    imm32   = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        case (funct3)
          3'b000: begin
            dec.alu_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
            illegal      = ((funct7 & 7'b1011111) != 7'd0);
          end
          3'b111:  begin dec.alu_ctrl = ALU_AND; illegal = (funct7 != 7'd0); end
          3'b110:  begin dec.alu_ctrl = ALU_OR;  illegal = (funct7 != 7'd0); end
          3'b100:  begin dec.alu_ctrl = ALU_XOR; illegal = (funct7 != 7'd0); end
          3'b010:  begin dec.alu_ctrl = ALU_SLT; illegal = (funct7 != 7'd0); end
          3'b001:  begin dec.alu_ctrl = ALU_SLL; illegal = (funct7 != 7'd0); end
          3'b101:  begin dec.alu_ctrl = ALU_SRL; illegal = (funct7 != 7'd0); end
          default: illegal = 1'b1;
        endcase
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm32         = {{20{InstrD[31]}}, InstrD[31:20]};
        case (funct3)
          3'b000:  dec.alu_ctrl = ALU_ADD;
          3'b111:  dec.alu_ctrl = ALU_AND;
          3'b110:  dec.alu_ctrl = ALU_OR;
          3'b100:  dec.alu_ctrl = ALU_XOR;
          3'b010:  dec.alu_ctrl = ALU_SLT;
          // Shift immediates carry a funct7; only the logical form is supported.
          3'b001:  begin dec.alu_ctrl = ALU_SLL; illegal = (funct7 != 7'd0); end
          3'b101:  begin dec.alu_ctrl = ALU_SRL; illegal = (funct7 != 7'd0); end
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
        dec.alu_ctrl   = ALU_ADD;
        imm32          = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
        imm32         = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_BRANCH: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        imm32        = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                        InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        dec.alu_ctrl   = ALU_ADD;
        imm32          = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                          InstrD[20], InstrD[30:21], 1'b0};
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
        imm32         = {InstrD[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase

    if (illegal && NOP_ON_ILLEGAL) begin
      dec.reg_write  = 1'b0;
      dec.mem_write  = 1'b0;
      dec.jump       = 1'b0;
      dec.branch     = 1'b0;
      dec.alu_src    = 1'b0;
      dec.result_src = RES_ALU;
      dec.alu_ctrl   = ALU_ADD;
    end

    dec.imm     = XLEN'($signed(imm32));
    dec.rd1     = rd1_byp;
    dec.rd2     = rd2_byp;
    dec.pc      = PCD;
    dec.pc4     = PCPlus4D;
    // lui has no rs1; a zero index keeps forwarding logic from matching imm bits.
    dec.rs1     = (opcode == OP_LUI) ? 5'd0 : A1;
    dec.rs2     = A2;
    dec.rd      = InstrD[11:7];
    dec.valid   = 1'b1;
    dec.illegal = illegal;
  end

  always_comb begin
    idex_d = idex_q;
    if (FlushE) begin
      idex_d = '0;
    end else if (!StallE) begin
      idex_d = ValidD ? dec : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_ctrl;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc4;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign ValidE      = idex_q.valid;
  assign IllegalE    = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed expectations for each
// instruction class, bypass, stall/flush priority and asynchronous reset.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, StallE, FlushE;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ValidE, IllegalE;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(32), .NOP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ValidE(ValidE), .IllegalE(IllegalE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2);
    InstrD = instr;
    RD1    = r1;
    RD2    = r2;
    ValidD = 1'b1;
  endtask

  initial begin
    rst = 1'b0; InstrD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h0;
    ValidD = 1'b0; StallE = 1'b0; FlushE = 1'b0; RD1 = 32'h0; RD2 = 32'h0;
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0;

    #12;
    check("rst_valid", ValidE, 0);
    check("rst_regwrite", RegWriteE, 0);
    check("rst_rd1", RD1E, 0);
    @(negedge clk);
    rst = 1'b1;

    // add x7,x5,x6
    drive(32'h006283B3, 32'd5, 32'd4);
    PCD = 32'h100; PCPlus4D = 32'h104;
    #1;
    check("a1_comb", A1, 5);
    check("a2_comb", A2, 6);
    step;
    check("add_regwrite", RegWriteE, 1);
    check("add_aluctl", ALUControlE, 3'b000);
    check("add_alusrc", ALUSrcE, 0);
    check("add_rd", RdE, 7);
    check("add_rd1", RD1E, 5);
    check("add_rd2", RD2E, 4);
    check("add_valid", ValidE, 1);
    check("add_pc", PCE, 32'h100);
    check("add_pc4", PCPlus4E, 32'h104);

    // lw x9,-8(x2)
    drive(32'hFF812483, 32'd0, 32'd0);
    step;
    check("lw_imm", ImmExtE, 32'hFFFFFFF8);
    check("lw_ressrc", ResultSrcE, 2'b01);
    check("lw_alusrc", ALUSrcE, 1);
    check("lw_memwrite", MemWriteE, 0);
    check("lw_regwrite", RegWriteE, 1);

    // sw x9,12(x2)
    drive(32'h00912623, 32'd0, 32'd0);
    step;
    check("sw_imm", ImmExtE, 32'd12);
    check("sw_memwrite", MemWriteE, 1);
    check("sw_regwrite", RegWriteE, 0);

    // beq x1,x2,-16
    drive(32'hFE2088E3, 32'd0, 32'd0);
    step;
    check("beq_imm", ImmExtE, 32'hFFFFFFF0);
    check("beq_branch", BranchE, 1);
    check("beq_aluctl", ALUControlE, 3'b001);

    // jal x1,2048
    drive(32'h001000EF, 32'd0, 32'd0);
    step;
    check("jal_imm", ImmExtE, 32'h800);
    check("jal_jump", JumpE, 1);
    check("jal_ressrc", ResultSrcE, 2'b10);
    check("jal_rd", RdE, 1);

    // sub x7,x5,x6
    drive(32'h406283B3, 32'd9, 32'd3);
    step;
    check("sub_aluctl", ALUControlE, 3'b001);

    // srli x3,x4,2
    drive(32'h00225193, 32'd0, 32'd0);
    step;
    check("srli_aluctl", ALUControlE, 3'b111);
    check("srli_imm", ImmExtE, 32'd2);
    check("srli_illegal", IllegalE, 0);

    // srai is not supported
    drive(32'h40225193, 32'd0, 32'd0);
    step;
    check("srai_illegal", IllegalE, 1);
    check("srai_regwrite", RegWriteE, 0);

    // lui x5,0x12345
    drive(32'h123452B7, 32'd0, 32'd0);
    step;
    check("lui_imm", ImmExtE, 32'h12345000);
    check("lui_rs1", Rs1E, 0);
    check("lui_alusrc", ALUSrcE, 1);
    check("lui_regwrite", RegWriteE, 1);

    // bypass on rs1
    drive(32'h006283B3, 32'd5, 32'd4);
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
    step;
    check("byp1_rd1", RD1E, 32'hDEADBEEF);
    check("byp1_rd2", RD2E, 32'd4);

    // bypass on rs2
    RdW = 5'd6;
    step;
    check("byp2_rd1", RD1E, 32'd5);
    check("byp2_rd2", RD2E, 32'hDEADBEEF);

    // x0 never bypassed: add x7,x0,x6 with RdW=0
    drive(32'h006003B3, 32'd5, 32'd4);
    RdW = 5'd0;
    step;
    check("x0_rd1", RD1E, 32'd0);
    RegWriteW = 1'b0;

    // stall holds E while InstrD changes
    drive(32'h006283B3, 32'd11, 32'd22);
    step;
    StallE = 1'b1;
    drive(32'hFF812483, 32'd1, 32'd2);
    step;
    check("stall1_rd", RdE, 7);
    check("stall1_rd1", RD1E, 32'd11);
    drive(32'h00912623, 32'd3, 32'd4);
    #1;
    check("stall_a1_follows", A1, 2);
    step;
    check("stall2_imm", ImmExtE, 32'd0);
    check("stall2_memwrite", MemWriteE, 0);
    drive(32'hFE2088E3, 32'd5, 32'd6);
    step;
    check("stall3_branch", BranchE, 0);
    check("stall3_regwrite", RegWriteE, 1);
    check("stall3_rd2", RD2E, 32'd22);

    // flush beats stall
    FlushE = 1'b1;
    drive(32'h00912623, 32'd0, 32'd0);
    step;
    check("flush_valid", ValidE, 0);
    check("flush_regwrite", RegWriteE, 0);
    check("flush_memwrite", MemWriteE, 0);
    FlushE = 1'b0; StallE = 1'b0;

    // ValidD low loads a bubble
    drive(32'h006283B3, 32'd5, 32'd4);
    ValidD = 1'b0;
    step;
    check("bubble_valid", ValidE, 0);
    check("bubble_regwrite", RegWriteE, 0);

    // illegal opcode
    drive(32'h0000007F, 32'd0, 32'd0);
    step;
    check("ill_illegal", IllegalE, 1);
    check("ill_regwrite", RegWriteE, 0);
    check("ill_valid", ValidE, 1);

    // asynchronous reset mid-cycle with a valid instruction in E
    drive(32'h006283B3, 32'd5, 32'd4);
    step;
    check("pre_rst_valid", ValidE, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", ValidE, 0);
    check("arst_regwrite", RegWriteE, 0);
    check("arst_rd1", RD1E, 0);
    check("arst_rd", RdE, 0);
    @(negedge clk);
    rst = 1'b1;
    ValidD = 1'b0;
    step;
    check("post_rst_valid", ValidE, 0);
    drive(32'h006283B3, 32'd5, 32'd4);
    step;
    check("post_rst_load", ValidE, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
